// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: funct3 access codes, exception codes, FSM states.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_TIMEOUT  = 2'b10
    } exc_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        data     = '0;
        byte_sel = rdata[7:0];
        case (addr)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory handshake, store lane steering, wait-state stall with timeout, MEM/WB register.
//   state | meaning
//   IDLE  | no access outstanding; zero-wait accesses complete here
//   BUSY  | access issued, waiting for dm_ready; counter tracks wait cycles
module mem_stage
    import mem_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] exe_pc_to_reg,
    input  logic [31:0] exe_alu_out,
    input  logic [31:0] exe_rs2_data,
    input  logic [4:0]  exe_rd_addr,
    input  logic        exe_rdsrc,
    input  logic        exe_memtoreg,
    input  logic        exe_memwrite,
    input  logic        exe_memread,
    input  logic        exe_regwrite,
    input  logic [2:0]  exe_funct3,
    output logic        dm_req,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    output logic        mem_stall,
    output logic [31:0] mem_fwd_data,
    output logic [31:0] wb_rd_data,
    output logic [31:0] wb_load_data,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_regwrite,
    output logic        wb_memtoreg,
    output logic [1:0]  wb_exc
);

    state_e          state;
    logic [CNT_W-1:0] cnt;
    logic            access;
    logic            misalign;
    logic            abort;
    logic [3:0]      we_lanes;
    logic [31:0]     load_data;

    assign access   = exe_memread | exe_memwrite;
    assign misalign = ((exe_funct3[1:0] == 2'b01) & exe_alu_out[0]) |
                      ((exe_funct3[1:0] == 2'b10) & (exe_alu_out[1:0] != 2'b00));
    assign abort    = (state == BUSY) & ~dm_ready & (cnt == CNT_W'(TIMEOUT_CYCLES));

    // Reset gates the request combinationally so an in-flight access is dropped at once.
    assign dm_req       = ~rst & ((state == IDLE) ? (access & ~misalign) : ~abort);
    assign mem_stall    = dm_req & ~dm_ready & ~abort;
    assign dm_addr      = {exe_alu_out[31:2], 2'b00};
    assign dm_we        = (dm_req & exe_memwrite) ? we_lanes : 4'b0000;
    assign mem_fwd_data = exe_rdsrc ? exe_pc_to_reg : exe_alu_out;

    always_comb begin
        we_lanes = 4'b0000;
        dm_wdata = exe_rs2_data;
        case (exe_funct3[1:0])
            2'b00: begin
                dm_wdata = {4{exe_rs2_data[7:0]}};
                we_lanes = 4'b0001 << exe_alu_out[1:0];
            end
            2'b01: begin
                dm_wdata = {2{exe_rs2_data[15:0]}};
                we_lanes = exe_alu_out[1] ? 4'b1100 : 4'b0011;
            end
            2'b10:   we_lanes = 4'b1111;
            default: we_lanes = 4'b0000;
        endcase
    end

    load_extend u_load_extend (
        .rdata  (dm_rdata),
        .addr   (exe_alu_out[1:0]),
        .funct3 (exe_funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (dm_req & ~dm_ready) begin
                    state <= BUSY;
                    cnt   <= CNT_W'(1);
                end
                BUSY: if (dm_ready | abort) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rd_data   <= '0;
            wb_load_data <= '0;
            wb_rd_addr   <= '0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_exc       <= EXC_NONE;
        end else if (mem_stall) begin
            wb_regwrite <= 1'b0;
            wb_exc      <= EXC_NONE;
        end else if (access & misalign) begin
            wb_regwrite <= 1'b0;
            wb_exc      <= EXC_MISALIGN;
        end else if (abort) begin
            wb_regwrite <= 1'b0;
            wb_exc      <= EXC_TIMEOUT;
        end else begin
            wb_rd_data   <= mem_fwd_data;
            wb_load_data <= load_data;
            wb_rd_addr   <= exe_rd_addr;
            wb_regwrite  <= exe_regwrite;
            wb_memtoreg  <= exe_memtoreg;
            wb_exc       <= EXC_NONE;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed plan cases plus randomized ops against a byte-level model.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] exe_pc_to_reg = '0;
    logic [31:0] exe_alu_out = '0;
    logic [31:0] exe_rs2_data = '0;
    logic [4:0]  exe_rd_addr = '0;
    logic        exe_rdsrc = 1'b0;
    logic        exe_memtoreg = 1'b0;
    logic        exe_memwrite = 1'b0;
    logic        exe_memread = 1'b0;
    logic        exe_regwrite = 1'b0;
    logic [2:0]  exe_funct3 = '0;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata = '0;
    logic        dm_ready = 1'b0;
    logic        mem_stall;
    logic [31:0] mem_fwd_data;
    logic [31:0] wb_rd_data;
    logic [31:0] wb_load_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_regwrite;
    logic        wb_memtoreg;
    logic [1:0]  wb_exc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .exe_pc_to_reg(exe_pc_to_reg), .exe_alu_out(exe_alu_out), .exe_rs2_data(exe_rs2_data),
        .exe_rd_addr(exe_rd_addr), .exe_rdsrc(exe_rdsrc), .exe_memtoreg(exe_memtoreg),
        .exe_memwrite(exe_memwrite), .exe_memread(exe_memread), .exe_regwrite(exe_regwrite),
        .exe_funct3(exe_funct3),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .mem_stall(mem_stall), .mem_fwd_data(mem_fwd_data),
        .wb_rd_data(wb_rd_data), .wb_load_data(wb_load_data), .wb_rd_addr(wb_rd_addr),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_exc(wb_exc)
    );

    // Reference model: arithmetic on byte offsets, independent of the RTL structure.
    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned sz = 32'(f3) % 4;
        return (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0);
    endfunction

    function automatic logic [3:0] m_we(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned off = addr % 4;
        case (32'(f3) % 4)
            0: return 4'(1 << off);
            1: return (off >= 2) ? 4'b1100 : 4'b0011;
            2: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        case (32'(f3) % 4)
            0: return (rs2 & 32'hFF) * 32'h01010101;
            1: return (rs2 & 32'hFFFF) * 32'h00010001;
            default: return rs2;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int unsigned off = addr % 4;
        logic [31:0] b = (rdata >> (8 * off)) & 32'hFF;
        logic [31:0] h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd2: return rdata;
            3'd4: return b;
            3'd5: return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic apply(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic regw);
        exe_memread   = rd;
        exe_memwrite  = wr;
        exe_funct3    = f3;
        exe_alu_out   = addr;
        exe_rs2_data  = rs2;
        exe_regwrite  = regw;
        exe_memtoreg  = rd;
        exe_rd_addr   = 5'($urandom);
        exe_pc_to_reg = $urandom;
        exe_rdsrc     = 1'($urandom);
    endtask

    task automatic test_reset;
        apply(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 1'b1);
        dm_ready = 1'b0;
        @(posedge clk); #1;
        checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL rst_dm_req got %b exp 0", dm_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", mem_stall); end
        checks++; if ({wb_rd_data, wb_load_data, wb_rd_addr, wb_regwrite, wb_memtoreg, wb_exc} !== '0) begin
            errors++; $display("FAIL rst_wb got rd=%h ld=%h a=%0d rw=%b mt=%b exc=%b exp all 0",
                               wb_rd_data, wb_load_data, wb_rd_addr, wb_regwrite, wb_memtoreg, wb_exc);
        end
        @(negedge clk);
        apply(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        @(negedge clk);
        apply(1'b0, 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 1'b0);
        dm_ready = 1'b1;
        #1;
        checks++; if (dm_we !== 4'b1111) begin errors++; $display("FAIL sw_we got %b exp 1111", dm_we); end
        checks++; if (dm_addr !== 32'h104) begin errors++; $display("FAIL sw_addr got %h exp 00000104", dm_addr); end
        checks++; if (dm_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h exp deadbeef", dm_wdata); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL sw_stall got %b exp 0", mem_stall); end
        @(posedge clk); #1;
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL sw_wb_rw got %b exp 0", wb_regwrite); end

        @(negedge clk);
        apply(1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5, 1'b0);
        #1;
        checks++; if (dm_we !== 4'b1000) begin errors++; $display("FAIL sb_we got %b exp 1000", dm_we); end
        checks++; if (dm_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", dm_wdata); end

        @(negedge clk);
        apply(1'b1, 1'b0, 3'd0, 32'h101, 32'h0, 1'b1);
        dm_rdata = 32'h00008000;
        @(posedge clk); #1;
        checks++; if (wb_load_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h exp ffffff80", wb_load_data); end
        @(negedge clk);
        apply(1'b1, 1'b0, 3'd4, 32'h101, 32'h0, 1'b1);
        @(posedge clk); #1;
        checks++; if (wb_load_data !== 32'h00000080) begin errors++; $display("FAIL lbu_data got %h exp 00000080", wb_load_data); end
        @(negedge clk);
        apply(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 1'b1);
        dm_rdata = 32'hBEEF0000;
        @(posedge clk); #1;
        checks++; if (wb_load_data !== 32'h0000BEEF) begin errors++; $display("FAIL lhu_data got %h exp 0000beef", wb_load_data); end
    endtask

    task automatic test_misalign;
        @(negedge clk);
        apply(1'b1, 1'b0, 3'd1, 32'h201, 32'h0, 1'b1);
        dm_ready = 1'b1;
        #1;
        checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL lh_mis_req got %b exp 0", dm_req); end
        @(posedge clk); #1;
        checks++; if (wb_exc !== 2'b01) begin errors++; $display("FAIL lh_mis_exc got %b exp 01", wb_exc); end
        checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL lh_mis_rw got %b exp 0", wb_regwrite); end
        @(negedge clk);
        apply(1'b0, 1'b1, 3'd2, 32'h202, 32'h12345678, 1'b0);
        #1;
        checks++; if (dm_we !== 4'b0000) begin errors++; $display("FAIL sw_mis_we got %b exp 0000", dm_we); end
        checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL sw_mis_req got %b exp 0", dm_req); end
        @(posedge clk); #1;
        checks++; if (wb_exc !== 2'b01) begin errors++; $display("FAIL sw_mis_exc got %b exp 01", wb_exc); end
    endtask

    task automatic test_random;
        logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 40; i++) begin
            int kind = $urandom_range(0, 2);
            logic rd = (kind == 1);
            logic wr = (kind == 2);
            logic [2:0] f3 = (kind == 1) ? lf3[$urandom_range(0, 4)] :
                             (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom);
            logic [31:0] addr = $urandom;
            logic [31:0] rs2 = $urandom;
            logic [31:0] rdata = $urandom;
            logic regw = 1'($urandom);
            bit acc = rd || wr;
            bit mis = acc && m_mis(f3, addr);
            logic [31:0] fwd;
            logic [4:0] rda;
            @(negedge clk);
            apply(rd, wr, f3, addr, rs2, regw);
            dm_rdata = rdata;
            dm_ready = 1'b1;
            fwd = exe_rdsrc ? exe_pc_to_reg : addr;
            rda = exe_rd_addr;
            #1;
            checks++; if (dm_req !== (acc && !mis)) begin errors++; $display("FAIL rnd_req[%0d] got %b exp %b", i, dm_req, acc && !mis); end
            checks++; if (dm_we !== ((wr && !mis) ? m_we(f3, addr) : 4'b0)) begin
                errors++; $display("FAIL rnd_we[%0d] got %b exp %b", i, dm_we, (wr && !mis) ? m_we(f3, addr) : 4'b0);
            end
            checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rnd_stall[%0d] got %b exp 0", i, mem_stall); end
            checks++; if (mem_fwd_data !== fwd) begin errors++; $display("FAIL rnd_fwd[%0d] got %h exp %h", i, mem_fwd_data, fwd); end
            checks++; if (dm_addr !== (addr & 32'hFFFFFFFC)) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, dm_addr, addr & 32'hFFFFFFFC); end
            if (wr && !mis) begin
                checks++; if (dm_wdata !== m_wdata(f3, rs2)) begin errors++; $display("FAIL rnd_wdata[%0d] got %h exp %h", i, dm_wdata, m_wdata(f3, rs2)); end
            end
            @(posedge clk); #1;
            checks++; if (wb_exc !== (mis ? 2'b01 : 2'b00)) begin errors++; $display("FAIL rnd_exc[%0d] got %b exp %b", i, wb_exc, mis ? 2'b01 : 2'b00); end
            checks++; if (wb_regwrite !== (mis ? 1'b0 : regw)) begin errors++; $display("FAIL rnd_rw[%0d] got %b exp %b", i, wb_regwrite, mis ? 1'b0 : regw); end
            if (!mis) begin
                checks++; if (wb_rd_data !== fwd) begin errors++; $display("FAIL rnd_wbrd[%0d] got %h exp %h", i, wb_rd_data, fwd); end
                checks++; if (wb_rd_addr !== rda) begin errors++; $display("FAIL rnd_wbaddr[%0d] got %0d exp %0d", i, wb_rd_addr, rda); end
                checks++; if (wb_memtoreg !== rd) begin errors++; $display("FAIL rnd_wbmt[%0d] got %b exp %b", i, wb_memtoreg, rd); end
                if (rd) begin
                    checks++; if (wb_load_data !== m_load(f3, addr, rdata)) begin
                        errors++; $display("FAIL rnd_load[%0d] got %h exp %h", i, wb_load_data, m_load(f3, addr, rdata));
                    end
                end
            end
        end
    endtask

    task automatic test_wait;
        int waits [6] = '{3, 0, 1, 2, 4, 3};
        logic [2:0] lf3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int k = 0; k < 6; k++) begin
            logic [2:0] f3 = (k == 0) ? 3'd2 : lf3[$urandom_range(0, 4)];
            logic [31:0] addr = (k == 0) ? 32'h300 : ($urandom & 32'hFFFFFFFC) | ((f3 == 3'd0 || f3 == 3'd4) ? 32'($urandom_range(0, 3)) : 32'h0);
            logic [31:0] rdata = $urandom;
            int stalls = 0;
            for (int c = 0; c <= waits[k]; c++) begin
                @(negedge clk);
                if (c == 0) apply(1'b1, 1'b0, f3, addr, 32'h0, 1'b1);
                dm_ready = (c == waits[k]);
                dm_rdata = (c == waits[k]) ? rdata : $urandom;
                #1;
                if (mem_stall === 1'b1) stalls++;
                checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL wait_req[%0d.%0d] got %b exp 1", k, c, dm_req); end
                @(posedge clk); #1;
                if (c < waits[k]) begin
                    checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL wait_bubble[%0d.%0d] got %b exp 0", k, c, wb_regwrite); end
                end else begin
                    checks++; if (wb_regwrite !== 1'b1) begin errors++; $display("FAIL wait_rw[%0d] got %b exp 1", k, wb_regwrite); end
                    checks++; if (wb_load_data !== m_load(f3, addr, rdata)) begin
                        errors++; $display("FAIL wait_data[%0d] got %h exp %h", k, wb_load_data, m_load(f3, addr, rdata));
                    end
                    checks++; if (wb_exc !== 2'b00) begin errors++; $display("FAIL wait_exc[%0d] got %b exp 00", k, wb_exc); end
                end
            end
            checks++; if (stalls != waits[k]) begin errors++; $display("FAIL wait_stall_cycles[%0d] got %0d exp %0d", k, stalls, waits[k]); end
        end
    endtask

    task automatic test_timeout;
        int stalls = 0;
        for (int c = 0; c <= TO; c++) begin
            @(negedge clk);
            if (c == 0) apply(1'b1, 1'b0, 3'd2, 32'h400, 32'h0, 1'b1);
            dm_ready = 1'b0;
            #1;
            if (mem_stall === 1'b1) stalls++;
            checks++; if (dm_req !== (c < TO)) begin errors++; $display("FAIL to_req[%0d] got %b exp %b", c, dm_req, c < TO); end
            @(posedge clk); #1;
            if (c == TO) begin
                checks++; if (wb_exc !== 2'b10) begin errors++; $display("FAIL to_exc got %b exp 10", wb_exc); end
                checks++; if (wb_regwrite !== 1'b0) begin errors++; $display("FAIL to_rw got %b exp 0", wb_regwrite); end
            end
        end
        checks++; if (stalls != TO) begin errors++; $display("FAIL to_stall_cycles got %0d exp %0d", stalls, TO); end
        @(negedge clk);
        apply(1'b1, 1'b0, 3'd2, 32'h404, 32'h0, 1'b1);
        dm_ready = 1'b1;
        dm_rdata = 32'hCAFEF00D;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL to_recover_stall got %b exp 0", mem_stall); end
        @(posedge clk); #1;
        checks++; if (wb_regwrite !== 1'b1 || wb_load_data !== 32'hCAFEF00D) begin
            errors++; $display("FAIL to_recover_wb got rw=%b data=%h exp rw=1 data=cafef00d", wb_regwrite, wb_load_data);
        end
    endtask

    task automatic test_reset_busy;
        @(negedge clk);
        apply(1'b1, 1'b0, 3'd2, 32'h500, 32'h0, 1'b1);
        dm_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL rstbusy_req got %b exp 0", dm_req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rstbusy_stall got %b exp 0", mem_stall); end
        checks++; if ({wb_rd_data, wb_load_data, wb_rd_addr, wb_regwrite, wb_memtoreg, wb_exc} !== '0) begin
            errors++; $display("FAIL rstbusy_wb got rd=%h ld=%h a=%0d rw=%b mt=%b exc=%b exp all 0",
                               wb_rd_data, wb_load_data, wb_rd_addr, wb_regwrite, wb_memtoreg, wb_exc);
        end
        @(negedge clk);
        apply(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        apply(1'b1, 1'b0, 3'd4, 32'h503, 32'h0, 1'b1);
        dm_ready = 1'b1;
        dm_rdata = 32'h9A000000;
        #1;
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rstbusy_idle_stall got %b exp 0", mem_stall); end
        @(posedge clk); #1;
        checks++; if (wb_load_data !== 32'h0000009A) begin errors++; $display("FAIL rstbusy_idle_data got %h exp 0000009a", wb_load_data); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_wait();
        test_misalign();
        test_timeout();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
